// File: rtl/sched_pkg.sv
// Shared types and constants for the round-robin process scheduler.
// Imported by the scheduler top and its quantum timer.
package sched_pkg;

  typedef enum logic [1:0] {
    OS_RUN,
    LOAD,
    PROC_RUN,
    SAVE
  } state_t;

  localparam int ADDR_W_DEF = 10;
  localparam int CNT_W      = 10;

  function automatic int pid_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/proc_scheduler_if.sv
// OS-side and PC-side signal bundle of the process scheduler.
// master drives requests and the PC readback; slave is the scheduler.
interface proc_scheduler_if #(
  parameter int ADDR_W = 10,
  parameter int PID_W  = 2
);

  logic              hlt;
  logic              tbl_we;
  logic [PID_W-1:0]  tbl_pid;
  logic [ADDR_W-1:0] tbl_pc;
  logic              exec;
  logic [PID_W-1:0]  exec_pid;
  logic              proc_exit;
  logic [ADDR_W-1:0] only_proc_pc;
  logic              proc_num;
  logic              change_proc_pc;
  logic [ADDR_W-1:0] stored_pc;
  logic [PID_W-1:0]  cur_pid;
  logic              preempted;
  logic              exited;
  logic              exec_err;

  modport master (
    output hlt, tbl_we, tbl_pid, tbl_pc,
    output exec, exec_pid, proc_exit,
    output only_proc_pc,
    input  proc_num, change_proc_pc,
    input  stored_pc, cur_pid,
    input  preempted, exited, exec_err
  );

  modport slave (
    input  hlt, tbl_we, tbl_pid, tbl_pc,
    input  exec, exec_pid, proc_exit,
    input  only_proc_pc,
    output proc_num, change_proc_pc,
    output stored_pc, cur_pid,
    output preempted, exited, exec_err
  );

endinterface

// File: rtl/quantum_timer.sv
// Counts non-halted process cycles of one slice.
// Holds at QUANTUM-1 so the count can never wrap.
module quantum_timer
  import sched_pkg::*;
#(
  parameter int QUANTUM = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] count;

  assign expire = enable && (count == CNT_W'(QUANTUM - 1));

  // count run cycles; cleared while the process PC is loaded
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/proc_scheduler.sv
// Round-robin scheduler feeding the PC block's process-PC controls.
// Loads a saved PC, runs one slice, then saves the PC or retires.
module proc_scheduler
  import sched_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NPROC   = 4,
  parameter int QUANTUM = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic bios_reset,
  proc_scheduler_if.slave bus
);

  localparam int PID_W = pid_w(NPROC);

  state_t            state;
  state_t            state_nx;
  logic              rst;
  logic [ADDR_W-1:0] tbl [NPROC];
  logic [NPROC-1:0]  vld;
  logic [PID_W-1:0]  pid;
  logic [ADDR_W-1:0] spc;
  logic              exit_q;
  logic              pre_q;
  logic              ext_q;
  logic              err_q;
  logic              take;
  logic              deny;
  logic              expire;
  logic              in_save;

  assign rst     = reset || bios_reset;
  assign in_save = (state == SAVE);

  quantum_timer #(
    .QUANTUM(QUANTUM)
  ) u_timer (
    .clk   (clk),
    .reset (rst),
    .clear (state == LOAD),
    .enable(state == PROC_RUN && !bus.hlt),
    .expire(expire)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OS_RUN;
    end else begin
      state <= state_nx;
    end
  end

  // next state and exec acceptance
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    deny     = 1'b0;
    unique case (state)
      OS_RUN: begin
        if (bus.exec) begin
          if (vld[bus.exec_pid]) begin
            take     = 1'b1;
            state_nx = LOAD;
          end else begin
            deny = 1'b1;
          end
        end
      end
      LOAD: state_nx = PROC_RUN;
      PROC_RUN: begin
        if (bus.proc_exit || expire) begin
          state_nx = SAVE;
        end
      end
      SAVE: state_nx = OS_RUN;
      default: state_nx = OS_RUN;
    endcase
  end

  // selected process, load PC, exit flag and result pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      pid    <= '0;
      spc    <= '0;
      exit_q <= 1'b0;
      pre_q  <= 1'b0;
      ext_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= deny;
      pre_q <= in_save && !exit_q;
      ext_q <= in_save && exit_q;
      if (take) begin
        pid <= bus.exec_pid;
        spc <= tbl[bus.exec_pid];
      end
      if (state == PROC_RUN) begin
        exit_q <= bus.proc_exit;
      end
    end
  end

  // PC table write port; the slice save beats an OS write to the same entry
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      for (int i = 0; i < NPROC; i++) begin
        if (in_save && pid == PID_W'(i)) begin
          if (exit_q) begin
            vld[i] <= 1'b0;
          end else begin
            tbl[i] <= bus.only_proc_pc;
          end
        end else if (bus.tbl_we && bus.tbl_pid == PID_W'(i)) begin
          tbl[i] <= bus.tbl_pc;
          vld[i] <= 1'b1;
        end
      end
    end
  end

  assign bus.proc_num       = (state == PROC_RUN);
  assign bus.change_proc_pc = (state == LOAD);
  assign bus.stored_pc      = spc;
  assign bus.cur_pid        = pid;
  assign bus.preempted      = pre_q;
  assign bus.exited         = ext_q;
  assign bus.exec_err       = err_q;

endmodule

// File: tb/tb_proc_scheduler.sv
// Bench for proc_scheduler: directed slices plus random traffic,
// every cycle compared against a slice-level reference model.
module tb_proc_scheduler;

  localparam int Q = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bios_reset = 1'b0;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  proc_scheduler_if #(.ADDR_W(10), .PID_W(2)) bus ();

  proc_scheduler #(
    .ADDR_W (10),
    .NPROC  (4),
    .QUANTUM(Q)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bios_reset(bios_reset),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // PC block stand-in: loads on change, advances while running
  always @(posedge clk) begin
    if (bus.change_proc_pc === 1'b1) begin
      bus.only_proc_pc <= bus.stored_pc;
    end else if (bus.proc_num === 1'b1 && !bus.hlt) begin
      bus.only_proc_pc <= bus.only_proc_pc + 10'd1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // reference model: phase 0 os, 1 load, 2 run, 3 save
  int         m_ph = 0;
  int         m_left = 0;
  bit         m_ex = 0;
  logic [1:0] m_pid = 0;
  logic [9:0] m_spc = 0;
  bit         m_pre = 0;
  bit         m_exd = 0;
  bit         m_err = 0;
  logic [9:0] m_tbl [4];
  bit         m_vld [4];

  always @(posedge clk) begin
    int ph0;
    ph0 = m_ph;
    if (reset || bios_reset) begin
      m_ph = 0; m_left = 0; m_ex = 0;
      m_pid = 0; m_spc = 0;
      m_pre = 0; m_exd = 0; m_err = 0;
      foreach (m_vld[i]) m_vld[i] = 0;
    end else begin
      m_pre = 0; m_exd = 0; m_err = 0;
      case (ph0)
        0: begin
          if (bus.exec) begin
            if (m_vld[bus.exec_pid]) begin
              m_pid = bus.exec_pid;
              m_spc = m_tbl[bus.exec_pid];
              m_ph = 1;
            end else begin
              m_err = 1;
            end
          end
        end
        1: begin
          m_ph = 2;
          m_left = Q;
        end
        2: begin
          if (bus.proc_exit) begin
            m_ex = 1; m_ph = 3;
          end else if (!bus.hlt) begin
            m_left--;
            if (m_left == 0) begin
              m_ex = 0; m_ph = 3;
            end
          end
        end
        default: begin
          if (m_ex) begin
            m_vld[m_pid] = 0; m_exd = 1;
          end else begin
            m_tbl[m_pid] = bus.only_proc_pc; m_pre = 1;
          end
          m_ph = 0;
        end
      endcase
      if (bus.tbl_we && !(ph0 == 3 && bus.tbl_pid == m_pid)) begin
        m_tbl[bus.tbl_pid] = bus.tbl_pc;
        m_vld[bus.tbl_pid] = 1;
      end
    end
  end

  // per-cycle comparison plus run-length / save-PC observation
  int         pn_len = 0;
  int         last_run = 0;
  logic [9:0] save_pc = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("proc_num", bus.proc_num, m_ph == 2);
      check("change_proc_pc", bus.change_proc_pc, m_ph == 1);
      check("stored_pc", bus.stored_pc, m_spc);
      check("cur_pid", bus.cur_pid, m_pid);
      check("preempted", bus.preempted, m_pre);
      check("exited", bus.exited, m_exd);
      check("exec_err", bus.exec_err, m_err);
    end
    if (bus.proc_num === 1'b1) begin
      pn_len++;
    end else if (pn_len > 0) begin
      last_run = pn_len;
      pn_len = 0;
      save_pc = bus.only_proc_pc;
    end
  end

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_low(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      nstep();
      if (bus.proc_num === 1'b0) begin
        ok = 1;
        break;
      end
    end
    check({"end_of_run_", nm}, ok, 1);
  endtask

  task automatic do_exec(input logic [1:0] p);
    bus.exec = 1; bus.exec_pid = p;
    nstep();
    bus.exec = 0;
  endtask

  task automatic do_wr(input logic [1:0] p, input logic [9:0] pc);
    bus.tbl_we = 1; bus.tbl_pid = p; bus.tbl_pc = pc;
    nstep();
    bus.tbl_we = 0;
  endtask

  initial begin
    bus.hlt = 0; bus.tbl_we = 0; bus.tbl_pid = 0; bus.tbl_pc = 0;
    bus.exec = 0; bus.exec_pid = 0; bus.proc_exit = 0;
    bus.only_proc_pc = 0;
    nstep(); nstep();
    chk_en = 1;
    nstep();
    reset = 0;
    check("rst_proc_num", bus.proc_num, 0);
    check("rst_stored_pc", bus.stored_pc, 0);

    // load and run pid1 from 0x040
    do_wr(2'd1, 10'h040);
    do_exec(2'd1);
    check("load_change", bus.change_proc_pc, 1);
    check("load_pc", bus.stored_pc, 10'h040);
    check("load_pn", bus.proc_num, 0);
    nstep();
    check("run_pn", bus.proc_num, 1);
    wait_low("s1");
    check("slice_len", last_run, 8);
    check("save_pc", save_pc, 10'h048);
    nstep();
    check("pre_pulse", bus.preempted, 1);

    // resume pid1 with a 5-cycle halt mid-slice
    do_exec(2'd1);
    check("reload_pc", bus.stored_pc, 10'h048);
    nstep();
    bus.hlt = 1;
    repeat (5) nstep();
    bus.hlt = 0;
    wait_low("s2");
    check("halt_len", last_run, 13);
    nstep();
    check("pre_pulse2", bus.preempted, 1);

    // exit on the last quantum cycle
    do_exec(2'd1);
    nstep();
    repeat (7) nstep();
    bus.proc_exit = 1;
    nstep();
    bus.proc_exit = 0;
    check("exit_pn", bus.proc_num, 0);
    check("exit_len", last_run, 8);
    nstep();
    check("exit_pulse", bus.exited, 1);
    check("exit_nopre", bus.preempted, 0);
    do_exec(2'd1);
    check("dead_err", bus.exec_err, 1);
    check("dead_load", bus.change_proc_pc, 0);
    nstep();
    check("dead_pn", bus.proc_num, 0);

    // bios_reset mid-slice
    do_wr(2'd2, 10'h200);
    do_wr(2'd0, 10'h010);
    do_exec(2'd2);
    nstep();
    repeat (2) nstep();
    bios_reset = 1;
    nstep();
    bios_reset = 0;
    check("bios_pn", bus.proc_num, 0);
    check("bios_pid", bus.cur_pid, 0);
    for (int p = 0; p < 4; p++) begin
      do_exec(2'(p));
      check("bios_err", bus.exec_err, 1);
      check("bios_noload", bus.change_proc_pc, 0);
    end
    nstep();

    // OS write collides with the save of the same entry
    do_wr(2'd1, 10'h0c0);
    do_exec(2'd1);
    nstep();
    wait_low("s5");
    bus.tbl_we = 1; bus.tbl_pid = 2'd1; bus.tbl_pc = 10'h100;
    nstep();
    bus.tbl_we = 0;
    check("coll_pre", bus.preempted, 1);
    do_exec(2'd1);
    check("coll_pc", bus.stored_pc, 10'h0c8);
    repeat (12) nstep();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      bus.tbl_we = ($urandom_range(0, 3) == 0);
      bus.tbl_pid = 2'($urandom_range(0, 3));
      bus.tbl_pc = 10'($urandom);
      bus.exec = ($urandom_range(0, 4) == 0);
      bus.exec_pid = 2'($urandom_range(0, 3));
      bus.proc_exit = ($urandom_range(0, 19) == 0);
      bus.hlt = ($urandom_range(0, 4) == 0);
      bios_reset = ($urandom_range(0, 99) == 0);
      nstep();
    end
    bus.tbl_we = 0; bus.exec = 0; bus.proc_exit = 0;
    bus.hlt = 0; bios_reset = 0;
    nstep(); nstep();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/proc_scheduler.md
# proc_scheduler

Round-robin process scheduler sitting directly upstream of the program counter. Drives the PC's `proc_num`, `change_proc_pc` and `stored_pc` inputs and reads back `only_proc_pc`. Holds a saved-PC table for up to NPROC processes. On an OS `exec` it loads a process PC, runs the process for a bounded quantum, then saves the process PC and returns control to the OS PC.

## Interface
Parameters:
- ADDR_W, 10, instruction address width; matches the PC.
- NPROC, 4, process table entries; power of two.
- QUANTUM, 64, process run cycles per slice; range 2..1023.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- bios_reset  in  1  synchronous abort to OS; same effect as reset.
- hlt  in  1  CPU halt; freezes the quantum count.
- tbl_we  in  1  OS writes a table entry.
- tbl_pid  in  log2(NPROC)  entry index for tbl_we.
- tbl_pc  in  ADDR_W  start PC written to the entry; sets its valid bit.
- exec  in  1  OS requests a run of process exec_pid; 1-cycle pulse.
- exec_pid  in  log2(NPROC)  process to run.
- proc_exit  in  1  running process executed its exit instruction.
- only_proc_pc  in  ADDR_W  current process PC from the PC block.
- proc_num  out  1  1 selects the process PC.
- change_proc_pc  out  1  PC block loads stored_pc into its process PC.
- stored_pc  out  ADDR_W  PC to load.
- cur_pid  out  log2(NPROC)  process currently or most recently run.
- preempted  out  1  1-cycle pulse: slice expired and PC saved.
- exited  out  1  1-cycle pulse: process exited and entry invalidated.
- exec_err  out  1  1-cycle pulse: exec to an invalid entry.

## Operation
- States:
  - OS_RUN: proc_num=0.
  - LOAD: proc_num=0, change_proc_pc=1.
  - PROC_RUN: proc_num=1.
  - SAVE: proc_num=0.
- All outputs are decoded from registered state and registers; no input-to-output combinational path.
- OS_RUN:
  - exec with valid[exec_pid]=1: latch cur_pid=exec_pid; stored_pc=table[exec_pid]; go to LOAD.
  - exec with valid=0: pulse exec_err next cycle; stay in OS_RUN.
- LOAD: one cycle; the PC block captures stored_pc; clear the quantum counter; go to PROC_RUN.
- PROC_RUN:
  - Counter increments each cycle with hlt=0.
  - proc_exit: go to SAVE with an exit flag. proc_exit has priority over counter==QUANTUM-1.
  - Otherwise, counter==QUANTUM-1 with hlt=0: go to SAVE.
- SAVE: one cycle.
  - Exit path: valid[cur_pid]<=0; pulse exited.
  - Preempt path: table[cur_pid]<=only_proc_pc; pulse preempted.
  - Then go to OS_RUN.
- exec outside OS_RUN is ignored, with no error.
- tbl_we is accepted in any state. If tbl_we and a SAVE write hit the same entry in the same cycle, SAVE wins.
- reset or bios_reset:
  - next state OS_RUN; all valid bits cleared; counter 0.
  - overrides everything, mid-slice included.
- Reset values: proc_num 0, change_proc_pc 0, stored_pc 0, cur_pid 0, preempted 0, exited 0, exec_err 0; table contents don't-care (valid=0).

## Timing
- exec sampled at edge N:
  - LOAD during cycle N+1.
  - proc_num=1 from cycle N+2.
  - First process fetch at table[pid] in cycle N+2.
- Slice length: exactly QUANTUM non-halted cycles with proc_num=1. Halted cycles extend the slice.
- Expiry at edge M: SAVE during M+1, where only_proc_pc already holds the next-to-execute address. Pulse and OS_RUN in M+2.
- exec can be re-accepted in the first OS_RUN cycle.
- Counter width is 10 bits; it never wraps, because it is cleared in LOAD and stops at QUANTUM-1.

## Structure
- Package `sched_pkg`:
  - state enum (OS_RUN, LOAD, PROC_RUN, SAVE).
  - ADDR_W default.
  - PID width function clog2(NPROC).
- Sub-module `quantum_timer`:
  - inputs clear, enable (state==PROC_RUN && !hlt).
  - output expire (count==QUANTUM-1 && enable).
- Table: NPROC×ADDR_W register array plus NPROC valid bits; write port mux inside proc_scheduler.

## Test plan
- Reset, tbl_we pid1 pc=0x040, exec pid1 -> change_proc_pc=1 and stored_pc=0x040 one cycle after exec; proc_num=1 the cycle after.
- QUANTUM=8, no hlt: proc_num high exactly 8 cycles; preempted pulses; table[1] equals only_proc_pc in SAVE; a second exec pid1 reloads that value.
- hlt for 5 cycles mid-slice, QUANTUM=8 -> proc_num high 13 cycles.
- proc_exit with counter==QUANTUM-1 -> exited pulses, preempted stays 0; a subsequent exec pid1 gives exec_err, proc_num stays 0.
- bios_reset during PROC_RUN -> proc_num=0 next cycle; all entries invalid; exec on any pid gives exec_err.
- tbl_we pid1 pc=0x100 in the SAVE cycle of pid1 -> table[1] holds the saved only_proc_pc, not 0x100.
